// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front-end that feeds the shared one-hot ALU datapath and returns tagged results.
// Optional macro ALU_ARB_OPERAND_CHECK_EN rejects non-one-hot operands and opcode 000 without running the datapath.
module alu_req_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_opc,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_opc,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,

    output logic [2:0]  alu_opc,
    output logic [15:0] alu_inp1,
    output logic [15:0] alu_inp2,
    input  logic [15:0] alu_out,
    input  logic        alu_ovf,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_ptr;
    logic                r_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [OPC_W-1:0]    r_alu_opc;
    logic [DATA_W-1:0]   r_alu_inp1;
    logic [DATA_W-1:0]   r_alu_inp2;

    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_result;
    logic                r_rsp_ovf;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_sel_id;
    logic [OPC_W-1:0]    w_sel_opc;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic                w_chk_fail;
    logic                w_load_exec;
    logic                w_load_err;
    logic                w_capture;
    logic                w_rsp_done;

    // Round-robin: with both ports requesting, the port not granted last wins.
    assign w_grant0   = req0_valid & (~req1_valid | r_ptr);
    assign w_grant1   = req1_valid & (~req0_valid | ~r_ptr);
    assign req0_ready = (r_state == S_IDLE) & ~rst & w_grant0;
    assign req1_ready = (r_state == S_IDLE) & ~rst & w_grant1;
    assign w_accept   = (req0_ready & req0_valid) | (req1_ready & req1_valid);

    assign w_sel_id   = req1_ready;
    assign w_sel_opc  = w_sel_id ? req1_opc : req0_opc;
    assign w_sel_a    = w_sel_id ? req1_a   : req0_a;
    assign w_sel_b    = w_sel_id ? req1_b   : req0_b;

`ifdef ALU_ARB_OPERAND_CHECK_EN
    function automatic logic is_onehot(input logic [DATA_W-1:0] v);
        return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
    endfunction

    assign w_chk_fail = ~is_onehot(w_sel_a) | ~is_onehot(w_sel_b) | (w_sel_opc == '0);
`else
    assign w_chk_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_exec = 1'b0;
        w_load_err  = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_chk_fail) begin
                        w_load_err  = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_load_exec = 1'b1;
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping and datapath operand registers; rejected requests still rotate the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= 1'b1;
            r_id       <= 1'b0;
            r_cnt      <= '0;
            r_alu_opc  <= '0;
            r_alu_inp1 <= '0;
            r_alu_inp2 <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_sel_id;
                r_id  <= w_sel_id;
            end
            if (w_load_exec) begin
                r_alu_opc  <= w_sel_opc;
                r_alu_inp1 <= w_sel_a;
                r_alu_inp2 <= w_sel_b;
                r_cnt      <= CNT_LOAD;
            end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_ovf    <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_result <= alu_out;
            r_rsp_ovf    <= alu_ovf;
        end else if (w_load_err) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_sel_id;
            r_rsp_result <= '0;
            r_rsp_ovf    <= 1'b0;
        end else if (w_rsp_done) begin
            r_rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_OPERAND_CHECK_EN
    logic r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err <= 1'b0;
        end else if (w_load_err) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign alu_opc    = r_alu_opc;
    assign alu_inp1   = r_alu_inp1;
    assign alu_inp2   = r_alu_inp2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_ovf    = r_rsp_ovf;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: EXEC_CYCLES=1 instance for arbitration/flow, EXEC_CYCLES=4 instance for mid-EXEC reset.
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_opc [2];
    logic [15:0] req_a   [2];
    logic [15:0] req_b   [2];
    logic [2:0]  alu_opc;
    logic [15:0] alu_inp1, alu_inp2, alu_out;
    logic        alu_ovf;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_err;
    logic [15:0] rsp_result;

    logic        d4_rst;
    logic [1:0]  d4_req_valid;
    logic [1:0]  d4_req_ready;
    logic [2:0]  d4_req_opc [2];
    logic [15:0] d4_req_a   [2];
    logic [15:0] d4_req_b   [2];
    logic [2:0]  d4_alu_opc;
    logic [15:0] d4_alu_inp1, d4_alu_inp2, d4_alu_out;
    logic        d4_alu_ovf;
    logic        d4_rsp_valid, d4_rsp_ready, d4_rsp_id, d4_rsp_ovf, d4_rsp_err;
    logic [15:0] d4_rsp_result;

    logic [18:0] sb_q [$];

    alu_req_arbiter #(.EXEC_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_opc(req_opc[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_opc(req_opc[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
        .alu_opc(alu_opc), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_out(alu_out), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    alu_req_arbiter #(.EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(d4_rst),
        .req0_valid(d4_req_valid[0]), .req0_ready(d4_req_ready[0]), .req0_opc(d4_req_opc[0]), .req0_a(d4_req_a[0]), .req0_b(d4_req_b[0]),
        .req1_valid(d4_req_valid[1]), .req1_ready(d4_req_ready[1]), .req1_opc(d4_req_opc[1]), .req1_a(d4_req_a[1]), .req1_b(d4_req_b[1]),
        .alu_opc(d4_alu_opc), .alu_inp1(d4_alu_inp1), .alu_inp2(d4_alu_inp2), .alu_out(d4_alu_out), .alu_ovf(d4_alu_ovf),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_id(d4_rsp_id), .rsp_result(d4_rsp_result),
        .rsp_ovf(d4_rsp_ovf), .rsp_err(d4_rsp_err)
    );

    function automatic int bit_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Behavioural stand-in for the one-hot ALU datapath: returns {ovf, result}.
    function automatic logic [16:0] alu_ref(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b);
        int ia, ib, s;
        logic [15:0] one;
        one = 16'h0001;
        ia  = bit_idx(a);
        ib  = bit_idx(b);
        case (opc)
            3'b001: begin s = ia + ib;      return {(s >= 16), one << s[3:0]}; end
            3'b010: begin s = ia - ib + 16; return {1'b0, one << s[3:0]}; end
            3'b011: return {1'b0, a};
            3'b100: return {1'b0, b};
            3'b101: return {1'b0, (ia >= ib) ? a : b};
            3'b110: return {1'b0, (ia < ib) ? a : b};
            3'b111: return {1'b0, b};
            default: return {1'b0, one};
        endcase
    endfunction

`ifdef ALU_ARB_OPERAND_CHECK_EN
    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
    endfunction
`endif

    // Expected response packed as {err, id, ovf, result}.
    function automatic logic [18:0] exp_rsp(input logic id, input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b);
`ifdef ALU_ARB_OPERAND_CHECK_EN
        if (!is_onehot(a) || !is_onehot(b) || (opc == 3'b000)) return {1'b1, id, 17'd0};
`endif
        return {1'b0, id, alu_ref(opc, a, b)};
    endfunction

    always_comb {alu_ovf, alu_out}       = alu_ref(alu_opc, alu_inp1, alu_inp2);
    always_comb {d4_alu_ovf, d4_alu_out} = alu_ref(d4_alu_opc, d4_alu_inp1, d4_alu_inp2);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Response monitor: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        logic [18:0] e;
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("rsp", 32'({rsp_err, rsp_id, rsp_ovf, rsp_result}), 32'(e));
            end
        end
    end

    task automatic wait_grant(input int max_cyc, output logic [1:0] got);
        got = 2'b00;
        for (int i = 0; i <= max_cyc; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                got = req_ready;
                return;
            end
            @(negedge clk);
        end
        chk("grant_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input int id, input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b);
        logic [1:0] got;
        req_opc[id]   = opc;
        req_a[id]     = a;
        req_b[id]     = b;
        req_valid[id] = 1'b1;
        wait_grant(8, got);
        chk("issue_grant", 32'(got), 32'(2'b01 << id));
        sb_q.push_back(exp_rsp(1'(id), opc, a, b));
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
        #3;
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] got;
        int last;

        rst = 1'b1; d4_rst = 1'b1;
        rsp_ready = 1'b1; d4_rsp_ready = 1'b1;
        req_valid = 2'b11; d4_req_valid = 2'b00;
        req_opc[0] = 3'b001; req_a[0] = 16'h0001; req_b[0] = 16'h0002;
        req_opc[1] = 3'b010; req_a[1] = 16'h0004; req_b[1] = 16'h0020;
        for (int i = 0; i < 2; i++) begin
            d4_req_opc[i] = 3'b000; d4_req_a[i] = 16'h0000; d4_req_b[i] = 16'h0000;
        end

        // Reset values, with both requesters already valid.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready",      32'(req_ready),  32'd0);
        chk("rst_alu_opc",    32'(alu_opc),    32'd0);
        chk("rst_alu_inp1",   32'(alu_inp1),   32'd0);
        chk("rst_alu_inp2",   32'(alu_inp2),   32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_ovf",    32'(rsp_ovf),    32'd0);
        chk("rst_rsp_err",    32'(rsp_err),    32'd0);
        @(negedge clk);
        rst = 1'b0; d4_rst = 1'b0;

        // Continuous contention: grants alternate 0,1,0,1 every 3 cycles.
        last = 0;
        for (int g = 0; g < 4; g++) begin
            wait_grant(6, got);
            chk("alt_grant", 32'(got), (g % 2 == 0) ? 32'd1 : 32'd2);
            if (g > 0) chk("alt_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            sb_q.push_back(exp_rsp(1'(g % 2), req_opc[g % 2], req_a[g % 2], req_b[g % 2]));
            @(negedge clk);
        end
        req_valid = 2'b00;
        drain(12);

        // Single add on port 0: operands at T+1, response at T+2.
        pulse_reset();
        issue(0, 3'b001, 16'h0008, 16'h0010);
        @(negedge clk); req_valid[0] = 1'b0; #1;
        chk("t1_alu_opc",   32'(alu_opc),   32'h1);
        chk("t1_alu_inp1",  32'(alu_inp1),  32'h0008);
        chk("t1_alu_inp2",  32'(alu_inp2),  32'h0010);
        chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        chk("t1_rsp_valid",  32'(rsp_valid),  32'd1);
        chk("t1_rsp_id",     32'(rsp_id),     32'd0);
        chk("t1_rsp_result", 32'(rsp_result), 32'h0080);
        chk("t1_rsp_ovf",    32'(rsp_ovf),    32'd0);
        @(negedge clk); #1;
        chk("t1_rsp_done",   32'(rsp_valid),  32'd0);

        // Subtract on port 1 wraps 2-5 to 13.
        @(negedge clk);
        issue(1, 3'b010, 16'h0004, 16'h0020);
        @(negedge clk); req_valid[1] = 1'b0;
        @(negedge clk); #1;
        chk("t3_rsp_valid",  32'(rsp_valid),  32'd1);
        chk("t3_rsp_id",     32'(rsp_id),     32'd1);
        chk("t3_rsp_result", 32'(rsp_result), 32'h2000);
        chk("t3_rsp_ovf",    32'(rsp_ovf),    32'd0);
        drain(6);

        // Back-pressure: response held, next port-0 request waits until after the handshake.
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(0, 3'b001, 16'h0100, 16'h0400);
        @(negedge clk);
        req_opc[0] = 3'b111; req_a[0] = 16'h0001; req_b[0] = 16'h8000;
        for (int i = 0; i < 6 && !rsp_valid; i++) @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(rsp_valid),    32'd1);
            chk("bp_id",     32'(rsp_id),       32'd0);
            chk("bp_result", 32'(rsp_result),   32'h0004);
            chk("bp_ovf",    32'(rsp_ovf),      32'd1);
            chk("bp_ready0", 32'(req_ready[0]), 32'd0);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        chk("bp_ready0_hs", 32'(req_ready[0]), 32'd0);
        @(negedge clk); #1;
        chk("bp_accept_after", 32'(req_ready[0]), 32'd1);
        sb_q.push_back(exp_rsp(1'b0, 3'b111, 16'h0001, 16'h8000));
        @(negedge clk); req_valid[0] = 1'b0;
        drain(8);

        // Malformed operands, then opcode 000.
        @(negedge clk);
        issue(0, 3'b001, 16'h0003, 16'h0010);
        @(negedge clk); req_valid[0] = 1'b0; #1;
`ifdef ALU_ARB_OPERAND_CHECK_EN
        chk("oc_a_rsp_valid", 32'(rsp_valid),  32'd1);
        chk("oc_a_rsp_err",   32'(rsp_err),    32'd1);
        chk("oc_a_rsp_res",   32'(rsp_result), 32'd0);
        chk("oc_a_alu_opc",   32'(alu_opc),    32'h7);
        chk("oc_a_alu_inp1",  32'(alu_inp1),   32'h0001);
        chk("oc_a_alu_inp2",  32'(alu_inp2),   32'h8000);
`else
        chk("nc_a_rsp_early", 32'(rsp_valid),  32'd0);
        chk("nc_a_alu_inp1",  32'(alu_inp1),   32'h0003);
`endif
        drain(8);
        @(negedge clk);
        issue(0, 3'b000, 16'h0002, 16'h0004);
        @(negedge clk); req_valid[0] = 1'b0; #1;
`ifdef ALU_ARB_OPERAND_CHECK_EN
        chk("oc_op_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("oc_op_rsp_err",   32'(rsp_err),   32'd1);
        chk("oc_op_alu_opc",   32'(alu_opc),   32'h7);
        chk("oc_op_alu_inp1",  32'(alu_inp1),  32'h0001);
`else
        chk("nc_op_rsp_early", 32'(rsp_valid), 32'd0);
        chk("nc_op_alu_opc",   32'(alu_opc),   32'h0);
`endif
        drain(8);

        // EXEC_CYCLES=4: reset in the 2nd EXEC cycle discards the operation.
        @(negedge clk);
        d4_req_opc[0] = 3'b001; d4_req_a[0] = 16'h0008; d4_req_b[0] = 16'h0010;
        d4_req_valid = 2'b01; #1;
        chk("d4_ready0", 32'(d4_req_ready), 32'd1);
        @(negedge clk); d4_req_valid = 2'b00; #1;
        chk("d4_alu_inp1_exec", 32'(d4_alu_inp1), 32'h0008);
        @(negedge clk); d4_rst = 1'b1;
        @(negedge clk); d4_rst = 1'b0; #1;
        chk("d4_rst_rsp_valid", 32'(d4_rsp_valid),  32'd0);
        chk("d4_rst_alu_opc",   32'(d4_alu_opc),    32'd0);
        chk("d4_rst_alu_inp1",  32'(d4_alu_inp1),   32'd0);
        chk("d4_rst_alu_inp2",  32'(d4_alu_inp2),   32'd0);
        chk("d4_rst_rsp_id",    32'(d4_rsp_id),     32'd0);
        chk("d4_rst_rsp_res",   32'(d4_rsp_result), 32'd0);
        chk("d4_rst_rsp_ovf",   32'(d4_rsp_ovf),    32'd0);
        chk("d4_rst_rsp_err",   32'(d4_rsp_err),    32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("d4_discarded", 32'(d4_rsp_valid), 32'd0);
        end
        @(negedge clk);
        d4_req_opc[1] = 3'b010; d4_req_a[1] = 16'h0004; d4_req_b[1] = 16'h0020;
        d4_req_valid = 2'b11; #1;
        chk("d4_rr_after_rst", 32'(d4_req_ready), 32'd1);
        @(negedge clk); d4_req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("d4_exec_no_rsp", 32'(d4_rsp_valid), 32'd0);
        end
        @(negedge clk); #1;
        chk("d4_rsp_valid",  32'(d4_rsp_valid),  32'd1);
        chk("d4_rsp_id",     32'(d4_rsp_id),     32'd0);
        chk("d4_rsp_result", 32'(d4_rsp_result), 32'h0080);

        @(negedge clk); #3;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
